mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/arb_grant_logic.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM encoding, port IDs and the read-return register layout.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int BURST_MAX_DEFAULT = 4;
  // Wide enough for BURST_MAX up to 15 (counter saturates at BURST_MAX-1).
  localparam int BURST_CNT_W = 4;

  typedef struct packed {
    logic vld;
    logic port;
  } rsp_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_grant_logic.sv
// Combinational grant decision for two ports: round-robin on ties from IDLE,
// owner keeps the port until its burst budget runs out while the other waits.
module arb_grant_logic
  import mem_port_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  arb_state_t             state,
  input  logic                   last_owner,
  input  logic [BURST_CNT_W-1:0] burst_cnt,
  input  logic                   req0,
  input  logic                   req1,
  output logic [1:0]             gnt
);

  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(BURST_MAX - 1);

  logic below_limit;

  assign below_limit = (burst_cnt < BURST_LAST);

  always_comb begin
    gnt = 2'b00;
    case (state)
      OWN0: begin
        if (req0 && (!req1 || below_limit)) gnt = 2'b01;
        else if (req1)                      gnt = 2'b10;
      end
      OWN1: begin
        if (req1 && (!req0 || below_limit)) gnt = 2'b10;
        else if (req0)                      gnt = 2'b01;
      end
      default: begin
        // With no owner, a tie goes to whichever port was not served last.
        if (req0 && req1) gnt = port_onehot(~last_owner);
        else              gnt = {req1, req0};
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port to single-port memory arbiter; grant and memory strobe are same-cycle.
// Read data returns one cycle after grant, tagged back to the issuing port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_rvalid,
  output logic          p1_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(BURST_MAX - 1);

  arb_state_t             state;
  logic                   last_owner;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [1:0]             gnt_raw;
  logic [1:0]             gnt;
  logic                   gnt_any;
  logic                   gnt_port;
  logic                   repeat_gnt;
  rsp_t                   rsp_q;

  arb_grant_logic #(
    .BURST_MAX (BURST_MAX)
  ) u_grant (
    .state      (state),
    .last_owner (last_owner),
    .burst_cnt  (burst_cnt),
    .req0       (p0_req),
    .req1       (p1_req),
    .gnt        (gnt_raw)
  );

  // Grants are held off while reset is asserted, even with requests pending.
  assign gnt        = resetn ? gnt_raw : 2'b00;
  assign gnt_any    = |gnt;
  assign gnt_port   = gnt[1] ? PORT1 : PORT0;
  assign repeat_gnt = ((state == OWN0) && gnt[0]) || ((state == OWN1) && gnt[1]);

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_owner <= PORT1;
      burst_cnt  <= '0;
    end else if (gnt_any) begin
      state      <= (gnt_port == PORT1) ? OWN1 : OWN0;
      last_owner <= gnt_port;
      if (!repeat_gnt)
        burst_cnt <= '0;
      else if (burst_cnt < BURST_LAST)
        burst_cnt <= burst_cnt + 1'b1;
    end else begin
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end

  // One outstanding read slot; the tag steers rvalid back to its issuer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_q <= '0;
    end else begin
      rsp_q.vld  <= gnt_any && !mem_we;
      rsp_q.port <= gnt_port;
    end
  end

  assign p0_rvalid = rsp_q.vld && (rsp_q.port == PORT0);
  assign p1_rvalid = rsp_q.vld && (rsp_q.port == PORT1);
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants
// and read returns; a monitor pops them whenever the DUT shows a grant or rvalid.
module tb_mem_port_arbiter;

  localparam logic [31:0] RD_MASK = 32'h5A5A_0000;

  typedef struct {
    logic [1:0]  gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } rexp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  // Second instance with BURST_MAX=1 for the immediate-handover case.
  logic        b_req0, b_req1, b_en;
  logic        b_g0, b_g1, b_rv0, b_rv1, b_men, b_mwe;
  logic [31:0] b_rd0, b_rd1, b_maddr, b_mwd;
  logic [31:0] b_zero = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  gexp_t gq[$];
  rexp_t rq[$];
  logic [1:0] bq[$];

  gexp_t mon_g;
  rexp_t mon_r;
  logic [1:0] mon_b;

  mem_port_arbiter #(.DW(32), .AW(32), .BURST_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.DW(32), .AW(32), .BURST_MAX(1)) dut_b (
    .clk(clk), .resetn(resetn),
    .p0_req(b_req0), .p0_we(1'b0), .p0_addr(b_zero), .p0_wdata(b_zero),
    .p1_req(b_req1), .p1_we(1'b0), .p1_addr(b_zero), .p1_wdata(b_zero),
    .p0_gnt(b_g0), .p1_gnt(b_g1), .p0_rvalid(b_rv0), .p1_rvalid(b_rv1),
    .p0_rdata(b_rd0), .p1_rdata(b_rd1),
    .mem_en(b_men), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwd),
    .mem_rdata(b_zero)
  );

  always #5 clk = ~clk;

  // Memory model: read data is a fixed function of the address, one cycle later.
  always @(posedge clk)
    mem_rdata <= (mem_en && !mem_we) ? (mem_addr ^ RD_MASK) : 32'hBAD0_BAD0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rn,
                       input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input int exp_port, input logic exp_rv);
    gexp_t g;
    rexp_t r;
    @(negedge clk);
    resetn = rn;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    b_req0 = r0 & b_en;
    b_req1 = r1 & b_en;
    if (exp_port == 0) begin
      g.gnt = 2'b01; g.we = w0; g.addr = a0; g.wdata = d0;
      gq.push_back(g);
      if (!w0 && exp_rv) begin
        r.port = 1'b0; r.rdata = a0 ^ RD_MASK;
        rq.push_back(r);
      end
    end else if (exp_port == 1) begin
      g.gnt = 2'b10; g.we = w1; g.addr = a1; g.wdata = d1;
      gq.push_back(g);
      if (!w1 && exp_rv) begin
        r.port = 1'b1; r.rdata = a1 ^ RD_MASK;
        rq.push_back(r);
      end
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 1'b0);
  endtask

  always @(negedge clk) begin
    #2;
    if (!resetn) begin
      check("reset_outputs",
            {p0_gnt, p1_gnt, mem_en, mem_we, mem_addr, mem_wdata, p0_rvalid, p1_rvalid},
            96'h0);
    end else begin
      check("gnt_legal", {p0_gnt & p1_gnt, p0_gnt & ~p0_req, p1_gnt & ~p1_req}, 96'h0);
      if (p0_gnt || p1_gnt || mem_en) begin
        if (gq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL grant_spurious: got gnt=%b%b en=%b addr=%h, required no grant",
                   p1_gnt, p0_gnt, mem_en, mem_addr);
        end else begin
          mon_g = gq.pop_front();
          check("grant", {p1_gnt, p0_gnt, mem_en, mem_we, mem_addr, mem_wdata},
                {mon_g.gnt, 1'b1, mon_g.we, mon_g.addr, mon_g.wdata});
        end
      end
      if (p0_rvalid || p1_rvalid) begin
        if (rq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rvalid_spurious: got rvalid=%b%b, required none", p1_rvalid, p0_rvalid);
        end else begin
          mon_r = rq.pop_front();
          check("rvalid", {p1_rvalid, p0_rvalid, (p1_rvalid ? p1_rdata : p0_rdata)},
                {port_bits(mon_r.port), mon_r.rdata});
        end
      end
      if (b_g0 || b_g1) begin
        if (bq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_grant_spurious: got gnt=%b%b, required none", b_g1, b_g0);
        end else begin
          mon_b = bq.pop_front();
          check("b_grant", {b_g1, b_g0}, mon_b);
        end
      end
    end
  end

  function automatic logic [1:0] port_bits(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

  initial begin
    int pat[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    resetn = 1'b0; b_en = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;

    // Requests held high through reset must not be granted.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, -1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, -1, 1'b0);

    // Tie from reset goes to port 0, then 4-deep bursts alternate; instance b hands over every cycle.
    b_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bq.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      drive(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i),
                  1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h2222_0000 + 32'(i), pat[i], 1'b1);
    end
    b_en = 1'b0;
    idle();

    // Single port read, then a port 1 write (no rvalid may follow it).
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1, 1'b0);
    idle();

    // Alternating reads back to back.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1, 1'b1);

    // Owner keeps the port past the burst limit while the other port is idle.
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1);
    // Saturated counter: contender wins immediately.
    drive(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h404, 32'h0, 1'b1, 1'b1, 32'h504, 32'hCAFE_F00D, 1, 1'b0);
    // Owner drops its request: other port granted the same cycle.
    drive(1'b1, 1'b1, 1'b0, 32'h408, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1);
    idle();

    // Reset lands while a read is outstanding; its rvalid must vanish.
    drive(1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 1'b0);
    idle();
    // last_owner was port 0 before reset; the reset value hands this tie to port 0.
    drive(1'b1, 1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 1'b0, 32'h800, 32'h0, 0, 1'b1);
    idle();
    idle();

    @(negedge clk);
    #5;
    check("grant_queue_drained", 96'(gq.size()), 96'h0);
    check("rvalid_queue_drained", 96'(rq.size()), 96'h0);
    check("b_queue_drained", 96'(bq.size()), 96'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
